// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package.
// Holds the stage occupancy encoding and the default datapath/control
// widths used by every pipeline stage register and by the hazard unit.
package pipe_stage_reg_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CTRL_W = 8;

  // Number of entries held by a stage; the value doubles as the occupancy
  // output so the encoding must stay 0/1/2.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one pipeline entry (valid + payload + control bundle).
// Used for both the main and the skid entry of pipe_stage_reg.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset; zeroes valid, data and ctrl
//   clear      - drop the entry: valid=0, ctrl=0, data keeps its last value
//   load       - capture load_data/load_ctrl and mark the entry valid
//   load_data  - payload to capture
//   load_ctrl  - control bundle to capture
//   valid      - entry present
//   data       - held payload
//   ctrl       - held control bundle (zero whenever valid=0)
module pipe_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload is reset as well so a freshly reset stage shows
      // out_data=0 instead of stale data from before reset.
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      // Bubble: control must read as zero, payload is left untouched.
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush.
// One-cycle latency, one entry per cycle sustained throughput, in-order.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   - two entries (main + skid); in_ready is registered and equals
//               (occupancy < 2), independent of out_ready.
//   undefined - single entry; in_ready = (!out_valid || out_ready) && !rst.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, overrides everything
//   flush      - discard all held entries and any same-cycle input
//   in_valid   - upstream entry present
//   in_ready   - stage accepts an entry this cycle
//   in_data    - upstream payload (DATA_W)
//   in_ctrl    - upstream control bundle (CTRL_W)
//   out_valid  - held entry present downstream
//   out_ready  - downstream consumes the entry
//   out_data   - held payload; keeps its last value when empty
//   out_ctrl   - held control bundle; all-zero when out_valid=0
//   occupancy  - entries held (0..2)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  occ_e              state_q;
  occ_e              state_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_load_data;
  logic [CTRL_W-1:0] main_load_ctrl;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_from_skid;

  // The skid entry is full exactly when occupancy is 2, so its valid flop
  // serves as the registered ready; rst only gates it during reset.
  assign in_ready = !skid_valid && !rst;

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );
`else
  // Accept when the single entry is free or is leaving this cycle.
  assign in_ready       = (!out_valid || out_ready) && !rst;
  assign main_load_data = in_data;
  assign main_load_ctrl = in_ctrl;
`endif

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      // Flush wins over any transfer; a same-cycle output is simply
      // dropped from the stage, never re-presented.
      state_d    = OCC_EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            // Downstream stalled: park the new entry behind the main one.
            skid_load = 1'b1;
            state_d   = OCC_TWO;
`endif
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = OCC_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        OCC_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = OCC_ONE;
          end
        end
`endif
        default: begin
          state_d    = OCC_EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (either build of PIPE_STAGE_SKID_EN).
// A queue model predicts the outputs every cycle; directed sequences add
// hand-computed literal expectations.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: FIFO of accepted entries ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_data = '0;

  function automatic logic model_in_ready();
    if (rst) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk) begin : model
    logic acc;
    logic pop;
    if (rst) begin
      q.delete();
      last_data <= '0;
    end else begin
      acc = in_valid && model_in_ready();
      pop = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({in_data, in_ctrl});
      end
      if (q.size() > 0) last_data <= q[0].d;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("cmp_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("cmp_occupancy", 32'(occupancy), 32'(q.size()));
      check("cmp_in_ready", 32'(in_ready), 32'(model_in_ready()));
      if (q.size() > 0) begin
        check("cmp_out_data", 32'(out_data), 32'(q[0].d));
        check("cmp_out_ctrl", 32'(out_ctrl), 32'(q[0].c));
      end else begin
        check("cmp_out_data_hold", 32'(out_data), 32'(last_data));
        check("cmp_out_ctrl_bubble", 32'(out_ctrl), 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with an entry presented: it must be lost.
    rst = 1'b1;
    drive(1'b1, 16'hBEEF, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ctrl", 32'(out_ctrl), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    step();
    #1;
    check("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("rst_release_in_ready", 32'(in_ready), 1);
    step();
    #1;
    check("rst_beef_lost", 32'(out_valid), 0);

    // Streaming 1..4 back to back.
    drive(1'b1, 16'd1, 8'h11, 1'b1, 1'b0);
    step();
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 16'(i), 8'(8'h11 * i), 1'b1, 1'b0);
      #1;
      check("stream_data", 32'(out_data), 32'(i - 1));
      check("stream_occ", 32'(occupancy), 1);
      step();
    end
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("stream_data_last", 32'(out_data), 4);
    check("stream_ctrl_last", 32'(out_ctrl), 32'h44);
    step();
    #1;
    check("stream_empty", 32'(out_valid), 0);
    check("stream_hold_data", 32'(out_data), 4);

    // Bubble mid-stream with in_ctrl=FF on the idle cycle.
    drive(1'b1, 16'd5, 8'h55, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'hDEAD, 8'hFF, 1'b1, 1'b0);
    #1;
    check("bubble_pre_valid", 32'(out_valid), 1);
    step();
    drive(1'b1, 16'd6, 8'h66, 1'b1, 1'b0);
    #1;
    check("bubble_valid", 32'(out_valid), 0);
    check("bubble_ctrl", 32'(out_ctrl), 0);
    step();
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("bubble_post_valid", 32'(out_valid), 1);
    check("bubble_post_data", 32'(out_data), 6);
    step();

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid entry.
    drive(1'b1, 16'h0A, 8'hA1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0B, 8'hB2, 1'b0, 1'b0);
    #1;
    check("bp_occ1", 32'(occupancy), 1);
    step();
    drive(1'b1, 16'h0C, 8'hC3, 1'b0, 1'b0);
    #1;
    check("bp_occ2", 32'(occupancy), 2);
    check("bp_in_ready", 32'(in_ready), 0);
    step();
    drive(1'b1, 16'h0C, 8'hC3, 1'b1, 1'b0);
    #1;
    check("bp_held_occ", 32'(occupancy), 2);
    check("bp_held_data", 32'(out_data), 32'h0A);
    step();
    #1;
    check("bp_out_b", 32'(out_data), 32'h0B);
    check("bp_occ_after", 32'(occupancy), 1);
    check("bp_ready_back", 32'(in_ready), 1);
    step();
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("bp_out_c", 32'(out_data), 32'h0C);
    step();
    #1;
    check("bp_drained", 32'(occupancy), 0);

    // Flush at occupancy 2 with an input presented.
    drive(1'b1, 16'h21, 8'h21, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h22, 8'h22, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h23, 8'h7E, 1'b0, 1'b1);
    #1;
    check("flush_pre_occ", 32'(occupancy), 2);
    step();
`else
    // Single entry: stall blocks input in the same cycle.
    drive(1'b1, 16'h31, 8'h31, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h32, 8'h32, 1'b0, 1'b0);
    #1;
    check("ns_stall_in_ready", 32'(in_ready), 0);
    step();
    #1;
    check("ns_stall_data", 32'(out_data), 32'h31);
    check("ns_stall_occ", 32'(occupancy), 1);
    out_ready = 1'b1;
    #1;
    check("ns_go_in_ready", 32'(in_ready), 1);
    step();
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("ns_swap_data", 32'(out_data), 32'h32);
    check("ns_swap_occ", 32'(occupancy), 1);
    step();

    // Flush with a same-cycle output transfer and an input presented.
    drive(1'b1, 16'h21, 8'h21, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h23, 8'h7E, 1'b1, 1'b1);
    #1;
    check("flush_pre_occ", 32'(occupancy), 1);
    step();
`endif
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #1;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ctrl", 32'(out_ctrl), 0);
    check("flush_occ", 32'(occupancy), 0);
    step();
    #1;
    check("flush_no_replay", 32'(out_valid), 0);
    step();

    // Reset overrides flush and an in-flight transfer.
    drive(1'b1, 16'h4242, 8'h42, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 16'h4343, 8'h43, 1'b1, 1'b1);
    #1;
    check("rst2_in_ready", 32'(in_ready), 0);
    step();
    #1;
    check("rst2_data", 32'(out_data), 0);
    check("rst2_occ", 32'(occupancy), 0);
    check("rst2_valid", 32'(out_valid), 0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    step();

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      step();
    end
    drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of the datapath payload (ALU result, store data, next PC).
REQ-002 The block SHALL have parameter CTRL_W, default 8, meaning the width of the control-signal bundle that is cleared on bubble or flush.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: stage accepts an entry this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: held entry present downstream.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the entry.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: held payload.
REQ-013 The block SHALL have port out_ctrl, output, CTRL_W bits: held control bundle.
REQ-014 The block SHALL have port occupancy, output, 2 bits: entries held (0..2).

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid && in_ready; an output transfer SHALL occur with out_valid && out_ready.
REQ-016 Latency SHALL be one cycle: an entry accepted at edge N is on out_* after edge N; sustained throughput SHALL be one entry per cycle.
REQ-017 Entries SHALL leave in acceptance order; there is no reordering and no duplication.
REQ-018 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble); out_data SHALL hold its last value when empty.
REQ-019 States: EMPTY (occupancy 0), ONE (main entry only), TWO (main + skid; skid build only).
REQ-020 EMPTY->ONE on input transfer; ONE->ONE on simultaneous in/out transfer; ONE->EMPTY on out transfer only; ONE->TWO on in transfer with out_ready=0.
REQ-021 TWO->ONE on out transfer, with the skid entry moving to main in the same edge; TWO SHALL NOT accept input (in_ready=0).
REQ-022 flush=1 SHALL force EMPTY at the next edge, clear out_valid and out_ctrl, and discard any same-cycle input; flush has priority over every transfer.
REQ-023 A same-cycle output transfer during flush SHALL still count as consumed downstream; the block SHALL NOT re-present it.
REQ-024 in_data/in_ctrl SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-025 rst=1 SHALL, at the next edge, set out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid contents=0.
REQ-026 While rst=1, in_ready SHALL be 0; on the first cycle after rst deasserts it SHALL be 1.
REQ-027 rst SHALL override flush and any in-flight transfer; an entry presented during reset SHALL be lost.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: a two-entry skid buffer SHALL be built; in_ready SHALL be a registered signal equal to (occupancy<2) and SHALL NOT depend combinationally on out_ready.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined: a single entry SHALL be built; in_ready SHALL equal (!out_valid || out_ready) && !rst combinationally; state TWO SHALL be unreachable; occupancy SHALL never exceed 1.

Structure
REQ-030 Occupancy state encoding and the default widths (16, 8) SHALL live in the shared pipeline package; the hazard unit and every stage instance import it.
REQ-031 A sub-module pipe_entry (valid, data, ctrl register with load and clear) SHALL be used for both the main and skid entries.

Verification
REQ-032 Reset: rst=1 for 2 cycles with in_valid=1 and in_data=16'hBEEF -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 after release.
REQ-033 Streaming: in_data 1,2,3,4 back-to-back with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one cycle delayed, occupancy=1 throughout.
REQ-034 Backpressure (skid): out_ready=0, feed 16'h0A then 16'h0B -> occupancy=2, in_ready=0, 16'h0C held upstream; release -> output 0A,0B,0C, in order, none lost.
REQ-035 Flush: occupancy=2 with in_valid=1 and flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed input is never output.
REQ-036 No-skid build: out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> simultaneous in/out transfer, occupancy remains 1.
REQ-037 Bubble: in_valid=0 for one cycle mid-stream with in_ctrl=8'hFF -> out_valid=0 and out_ctrl=8'h00 for exactly one cycle.
